// File: rtl/smi_self_rand_burst_scheduler.sv
// Round-robin burst scheduler: one random-word stream shared by 4 clients, one output register stage.
// Grant in cycle T gives first word at T+2; output stop stalls the source, requests are held off during a burst.
module smi_self_rand_burst_scheduler #(
   parameter int DataWidth   = 32,
   parameter int LengthWidth = 16
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic [3:0]                 reqReady,
   input  logic [4*LengthWidth-1:0]   reqLength,
   output logic [3:0]                 reqStop,
   input  logic                       randReady,
   input  logic [DataWidth-1:0]       randData,
   output logic                       randStop,
   output logic                       resultReady,
   output logic [DataWidth-1:0]       resultData,
   output logic [1:0]                 resultId,
   output logic                       resultLast,
   input  logic                       resultStop
);

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             ptr_q, ptr_d;
   logic [1:0]             id_q, id_d;
   logic [LengthWidth-1:0] rem_q, rem_d;
   logic                   vld_q, vld_d;
   logic [1:0]             rid_q, rid_d;
   logic                   last_q, last_d;
   logic [DataWidth-1:0]   data_q, data_d;

   logic                   any_req;
   logic                   found;
   logic [1:0]             win;
   logic [1:0]             idx;
   logic [LengthWidth-1:0] win_len;
   logic                   load;

   // First requesting client at or after the pointer, wrapping mod 4.
   always_comb begin
      any_req = |reqReady;
      found   = 1'b0;
      win     = ptr_q;
      idx     = ptr_q;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && reqReady[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      win_len = reqLength[int'(win)*LengthWidth +: LengthWidth];
   end

   assign load = (state_q == ST_BURST) && randReady && !(vld_q && resultStop);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      rem_d    = rem_q;
      reqStop  = 4'hF;
      randStop = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               reqStop = ~(4'b0001 << win);
               id_d    = win;
               ptr_d   = win + 2'd1;
               if (win_len != '0) begin
                  rem_d   = win_len;
                  state_d = ST_BURST;
               end
            end
         end
         ST_BURST: begin
            randStop = vld_q && resultStop;
            if (load) begin
               rem_d = rem_q - LengthWidth'(1);
               if (rem_q == LengthWidth'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Keep both handshakes closed while reset is applied so nothing is lost.
      if (srst) begin
         reqStop  = 4'hF;
         randStop = 1'b1;
      end
   end

   always_comb begin
      vld_d  = vld_q;
      rid_d  = rid_q;
      last_d = last_q;
      data_d = data_q;
      if (load) begin
         vld_d  = 1'b1;
         rid_d  = id_q;
         last_d = (rem_q == LengthWidth'(1));
         data_d = randData;
      end else if (vld_q && !resultStop) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= ST_IDLE;
         ptr_q   <= 2'd0;
         id_q    <= 2'd0;
         rem_q   <= '0;
         vld_q   <= 1'b0;
         rid_q   <= 2'd0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         rem_q   <= rem_d;
         vld_q   <= vld_d;
         rid_q   <= rid_d;
         last_q  <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign resultReady = vld_q;
   assign resultData  = data_q;
   assign resultId    = rid_q;
   assign resultLast  = last_q;

endmodule
